// File: rtl/puf_challenge_verifier.sv
// puf_challenge_verifier: issues a PUF challenge, times the oscillator window, captures and grades the response
// Ports:
//   clk, rst_n (async, active-high)      clock and reset
//   start, challenge, expected           request, challenge to issue, enrolled response
//   puf_resp                             raw PUF response (asynchronous to clk)
//   puf_sel, puf_ena, puf_clr            PUF challenge mux, oscillator enable, counter clear
//   busy, done                           operation in flight, one-cycle completion pulse
//   pass, err, hd, resp                  held result: HD within limit, unstable response, distance, captured value
module puf_challenge_verifier #(
  parameter int WINDOW = 64,
  parameter int SETTLE = 4,
  parameter int HD_MAX = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [4:0] challenge,
  input  logic [7:0] expected,
  input  logic [7:0] puf_resp,
  output logic [4:0] puf_sel,
  output logic       puf_ena,
  output logic       puf_clr,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       err,
  output logic [3:0] hd,
  output logic [7:0] resp
);
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_SETTLE, S_CAPTURE, S_DONE} state_t;
  localparam logic [15:0] WIN_M1 = 16'(WINDOW - 1);
  localparam logic [15:0] SET_M1 = 16'(SETTLE - 1);
  localparam logic [3:0]  HD_LIM = 4'(HD_MAX);
  state_t state, nxt;
  logic [15:0] cnt;
  logic [1:0]  retry;
  logic [7:0]  exp_q, s1, s2, s3;
  logic [3:0]  hd_now;
  assign hd_now = 4'($countones(s2 ^ exp_q));
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) state <= S_IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    puf_clr = 1'b0;
    puf_ena = 1'b0;
    busy = 1'b1;
    done = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        nxt = start ? S_CLEAR : S_IDLE;
      end
      S_CLEAR: begin
        puf_clr = 1'b1;
        nxt = (cnt == 16'd0) ? S_RUN : S_CLEAR;
      end
      S_RUN: begin
        puf_ena = 1'b1;
        nxt = (cnt == 16'd0) ? S_SETTLE : S_RUN;
      end
      S_SETTLE: nxt = (cnt == 16'd0) ? S_CAPTURE : S_SETTLE;
      S_CAPTURE: nxt = (s2 == s3 || retry == 2'd3) ? S_DONE : S_CAPTURE;
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
        nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) begin
      {s1, s2, s3} <= '0;
      cnt <= '0;
      retry <= '0;
      exp_q <= '0;
      puf_sel <= '0;
      pass <= 1'b0;
      err <= 1'b0;
      hd <= '0;
      resp <= '0;
    end else begin
      s1 <= puf_resp;
      s2 <= s1;
      s3 <= s2;
      // each timed phase reloads the shared down-counter on entry and leaves when it hits zero
      if (nxt != state) cnt <= (nxt == S_CLEAR) ? 16'd1 : (nxt == S_RUN) ? WIN_M1 : SET_M1;
      else if (cnt != 16'd0) cnt <= cnt - 16'd1;
      if (state == S_IDLE && start) begin
        puf_sel <= challenge;
        exp_q <= expected;
        retry <= '0;
        pass <= 1'b0;
        err <= 1'b0;
        hd <= '0;
        resp <= '0;
      end
      // s2 equal to s3 means the synchronized response held for two samples
      if (state == S_CAPTURE) begin
        if (s2 == s3) begin
          resp <= s2;
          hd <= hd_now;
          pass <= hd_now <= HD_LIM;
        end else if (retry == 2'd3) begin
          err <= 1'b1;
          pass <= 1'b0;
          resp <= s2;
          hd <= hd_now;
        end else retry <= retry + 2'd1;
      end
    end
endmodule

// File: tb/tb_puf_challenge_verifier.sv
// tb_puf_challenge_verifier: directed-vector bench for puf_challenge_verifier
module tb_puf_challenge_verifier;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [4:0] challenge = '0;
  logic [7:0] expected = '0;
  logic [7:0] puf_resp = '0;
  logic [4:0] puf_sel;
  logic       puf_ena, puf_clr, busy, done, pass, err;
  logic [3:0] hd;
  logic [7:0] resp;
  int vectors = 0;
  int miscompares = 0;
  int dc, ena_cnt, ena_first, ena_last, done_cnt, clr_cnt;
  bit clr_bad, overlap, sel_bad, busy_bad;

  puf_challenge_verifier dut (
    .clk(clk), .rst_n(rst_n), .start(start), .challenge(challenge), .expected(expected),
    .puf_resp(puf_resp), .puf_sel(puf_sel), .puf_ena(puf_ena), .puf_clr(puf_clr),
    .busy(busy), .done(done), .pass(pass), .err(err), .hd(hd), .resp(resp)
  );

  always #5 clk = ~clk;

  // Cycle n is the clock period ending at edge n; the start pulse is sampled at edge 0.
  // Observations are taken at the falling edge in the middle of each cycle.
  task automatic run_op(input logic [4:0] ch, input logic [7:0] ex, input bit tog, input int inj);
    dc = 0; ena_cnt = 0; ena_first = 0; ena_last = 0; done_cnt = 0; clr_cnt = 0;
    clr_bad = 0; overlap = 0; sel_bad = 0; busy_bad = 0;
    @(negedge clk);
    challenge = ch;
    expected = ex;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      if (puf_ena) begin
        ena_cnt++;
        if (ena_first == 0) ena_first = c;
        ena_last = c;
      end
      if (puf_clr) begin
        clr_cnt++;
        if (c > 2) clr_bad = 1;
      end
      if (puf_clr && puf_ena) overlap = 1;
      if (done) begin
        done_cnt++;
        if (dc == 0) dc = c;
      end
      if (dc == 0 && puf_sel !== ch) sel_bad = 1;
      if (busy !== (dc == 0)) busy_bad = 1;
      if (c == inj) begin
        start = 1'b1;
        challenge = 5'h1F;
      end else start = 1'b0;
      if (tog) puf_resp = (puf_resp == 8'h11) ? 8'h22 : 8'h11;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    bit ena_seen = 0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if ({puf_sel, puf_ena, puf_clr, busy, done, pass, err, hd, resp} !== 28'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want 0", {puf_sel, puf_ena, puf_clr, busy, done, pass, err, hd, resp});
    end
    for (int i = 0; i < 10; i++) begin
      if (puf_ena) ena_seen = 1;
      @(negedge clk);
    end
    vectors++;
    if (ena_seen !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_ena: got %0b want 0", ena_seen);
    end
  endtask

  task automatic test_exact_match;
    puf_resp = 8'h5C;
    run_op(5'h0A, 8'h5C, 0, 0);
    vectors++;
    if (dc !== 72) begin miscompares++; $display("FAIL exact_done_cycle: got %0d want 72", dc); end
    vectors++;
    if (ena_cnt !== 64 || ena_first !== 3 || ena_last !== 66) begin
      miscompares++;
      $display("FAIL exact_ena_window: got cnt=%0d first=%0d last=%0d want 64/3/66", ena_cnt, ena_first, ena_last);
    end
    vectors++;
    if (clr_cnt !== 2 || clr_bad !== 1'b0 || overlap !== 1'b0) begin
      miscompares++;
      $display("FAIL exact_clr: got cnt=%0d late=%0b overlap=%0b want 2/0/0", clr_cnt, clr_bad, overlap);
    end
    vectors++;
    if (puf_sel !== 5'h0A || sel_bad !== 1'b0 || busy_bad !== 1'b0) begin
      miscompares++;
      $display("FAIL exact_sel_busy: got sel=%h selbad=%0b busybad=%0b want 0a/0/0", puf_sel, sel_bad, busy_bad);
    end
    vectors++;
    if ({pass, err, hd, resp} !== {1'b1, 1'b0, 4'd0, 8'h5C}) begin
      miscompares++;
      $display("FAIL exact_result: got pass=%0b err=%0b hd=%0d resp=%h want 1/0/0/5c", pass, err, hd, resp);
    end
  endtask

  task automatic test_threshold;
    puf_resp = 8'h03;
    run_op(5'h05, 8'h00, 0, 0);
    vectors++;
    if (dc !== 72 || {pass, err, hd, resp} !== {1'b1, 1'b0, 4'd2, 8'h03}) begin
      miscompares++;
      $display("FAIL thresh_hd2: got done=%0d pass=%0b err=%0b hd=%0d resp=%h want 72/1/0/2/03", dc, pass, err, hd, resp);
    end
    puf_resp = 8'h07;
    run_op(5'h05, 8'h00, 0, 0);
    vectors++;
    if (dc !== 72 || {pass, err, hd, resp} !== {1'b0, 1'b0, 4'd3, 8'h07}) begin
      miscompares++;
      $display("FAIL thresh_hd3: got done=%0d pass=%0b err=%0b hd=%0d resp=%h want 72/0/0/3/07", dc, pass, err, hd, resp);
    end
  endtask

  task automatic test_unstable;
    puf_resp = 8'h11;
    run_op(5'h03, 8'h11, 1, 0);
    vectors++;
    if (dc !== 75 || done_cnt !== 1) begin
      miscompares++;
      $display("FAIL unstable_done: got cycle=%0d count=%0d want 75/1", dc, done_cnt);
    end
    vectors++;
    if (err !== 1'b1 || pass !== 1'b0) begin
      miscompares++;
      $display("FAIL unstable_flags: got err=%0b pass=%0b want 1/0", err, pass);
    end
    puf_resp = 8'h00;
  endtask

  task automatic test_start_while_busy;
    puf_resp = 8'h5C;
    run_op(5'h0A, 8'h5C, 0, 10);
    vectors++;
    if (done_cnt !== 1 || dc !== 72) begin
      miscompares++;
      $display("FAIL busy_start_done: got count=%0d cycle=%0d want 1/72", done_cnt, dc);
    end
    vectors++;
    if (sel_bad !== 1'b0 || puf_sel !== 5'h0A || pass !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_start_sel: got sel=%h selbad=%0b pass=%0b want 0a/0/1", puf_sel, sel_bad, pass);
    end
  endtask

  task automatic test_reset_mid_run;
    bit done_seen = 0;
    puf_resp = 8'h5C;
    @(negedge clk);
    challenge = 5'h0A;
    expected = 8'h5C;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 20; c++) @(negedge clk);
    vectors++;
    if (puf_ena !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midrun_active: got ena=%0b busy=%0b want 1/1", puf_ena, busy);
    end
    rst_n = 1'b1;
    #1;
    vectors++;
    if (puf_ena !== 1'b0 || busy !== 1'b0 || puf_sel !== 5'h00) begin
      miscompares++;
      $display("FAIL midrun_async_reset: got ena=%0b busy=%0b sel=%h want 0/0/00", puf_ena, busy, puf_sel);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (done) done_seen = 1;
      @(negedge clk);
    end
    vectors++;
    if (done_seen !== 1'b0) begin
      miscompares++;
      $display("FAIL midrun_no_done: got %0b want 0", done_seen);
    end
    run_op(5'h0A, 8'h5C, 0, 0);
    vectors++;
    if (dc !== 72 || pass !== 1'b1) begin
      miscompares++;
      $display("FAIL midrun_restart: got cycle=%0d pass=%0b want 72/1", dc, pass);
    end
  endtask

  initial begin
    test_reset;
    test_exact_match;
    test_threshold;
    test_unstable;
    test_start_while_busy;
    test_reset_mid_run;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/puf_challenge_verifier.md
# puf_challenge_verifier

Issuer/checker side of the ring-oscillator PUF. It drives the PUF's 5-bit challenge, oscillator enable and counter clear through a timed measurement window, then captures the 8-bit response through a synchronizer. It compares the response to an enrolled expected value by Hamming distance and reports pass/fail to the authentication controller.

## Interface
- WINDOW, 64: cycles `puf_ena` stays high per measurement (≥1, ≤65535).
- SETTLE, 4: cycles between oscillator disable and capture (≥3, covers the 2-flop synchronizer).
- HD_MAX, 2: largest Hamming distance (0–8) that still passes.
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-high (1 = reset), same polarity the PUF counters use on this port.
- start  in  1  one-cycle request; accepted only when `busy`=0.
- challenge  in  5  challenge; latched on accepted `start`.
- expected  in  8  enrolled response; latched on accepted `start`.
- puf_resp  in  8  PUF response, asynchronous to `clk`.
- puf_sel  out  5  challenge to PUF mux; holds latched value.
- puf_ena  out  1  oscillator enable.
- puf_clr  out  1  PUF counter clear, active-high.
- busy  out  1  high from the cycle after `start` is accepted until `done`.
- done  out  1  one-cycle pulse; result valid.
- pass  out  1  1 when the stable response has HD ≤ HD_MAX; held until next accept.
- err  out  1  1 when the response never stabilised; held until next accept.
- hd  out  4  Hamming distance (0–8) of captured response vs `expected`; held.
- resp  out  8  captured response; held.

## Operation
- Reset values: every output is 0. The FSM is in IDLE, and the latched challenge/expected registers are 0.
- `puf_resp` passes through a 2-flop synchronizer (`s1`→`s2`). A third register `s3` holds the previous `s2` value.
- FSM states: IDLE, CLEAR, RUN, SETTLE, CAPTURE, DONE.
  - IDLE: on `start`=1, latch `challenge` and `expected`, clear `pass`/`err`/`hd`/`resp`, then go to CLEAR.
  - CLEAR: `puf_clr`=1, `puf_ena`=0 for exactly 2 cycles, then go to RUN.
  - RUN: `puf_ena`=1 for exactly WINDOW cycles using a 16-bit down-counter, then go to SETTLE.
  - SETTLE: `puf_ena`=0 for SETTLE cycles, then go to CAPTURE.
  - CAPTURE: if `s2`==`s3`, store `resp`=`s2`, `hd`=popcount(`s2` XOR `expected`), and `pass`=(hd ≤ HD_MAX), then go to DONE.
    - Otherwise increment a 2-bit retry count.
    - On the 4th consecutive mismatch: `err`=1, `pass`=0, `resp`=`s2`, `hd` computed from `s2`, then go to DONE.
  - DONE: `done`=1 for one cycle, `busy` drops in the same cycle, then go to IDLE.
- `start` while `busy`=1 or in DONE: ignored, no queuing.
- `puf_sel` is stable through CLEAR, RUN, SETTLE and CAPTURE. Changing the `challenge` input mid-operation has no effect.
- `hd` arithmetic: unsigned 4-bit. HD_MAX=8 always passes. HD_MAX=0 requires an exact match.
- Reset asserted mid-operation: all outputs go to 0 immediately (asynchronously), FSM returns to IDLE, and no `done` is issued.

## Timing
- Cycle 0 is the edge at which `start` is sampled in IDLE.
- `busy`=1 and `puf_clr`=1 during cycles 1–2.
- `puf_ena`=1 during cycles 3 … WINDOW+2.
- SETTLE occupies cycles WINDOW+3 … WINDOW+SETTLE+2.
- CAPTURE first at cycle WINDOW+SETTLE+3.
- `done` at cycle WINDOW+SETTLE+4 with no retries. Defaults give cycle 72.
- Each retry adds 1 cycle. Worst case is `done` at WINDOW+SETTLE+7 with `err`=1.
- Back-to-back: next `start` is accepted the cycle after `done` (IDLE), so the minimum period is WINDOW+SETTLE+5.
- `puf_clr` and `puf_ena` are never high in the same cycle.

## Test plan
- Reset then idle: `rst_n`=1 for 3 cycles, release → all outputs 0; `start` never pulsed → `puf_ena` stays 0.
- Exact match, defaults: challenge=5'h0A, expected=8'h5C, `puf_resp` held at 8'h5C → `puf_sel`=0A; `puf_ena` high for 64 cycles; `done` at cycle 72; pass=1, hd=0, resp=5C, err=0.
- Threshold edge: expected=8'h00, `puf_resp`=8'h03 → hd=2, pass=1. Then `puf_resp`=8'h07 → hd=3, pass=0. `done` at cycle 72 both runs.
- Unstable response: `puf_resp` toggles every cycle between 8'h11 and 8'h22 through CAPTURE → `done` at cycle 75, err=1, pass=0.
- Start while busy: second `start` at cycle 10 with challenge=5'h1F → ignored, `puf_sel` remains the first challenge, exactly one `done`.
- Reset mid-RUN: assert `rst_n` at cycle 20 → `puf_ena`, `busy` and `puf_sel` go to 0 without a clock edge, and no `done`. A new `start` after release yields `done` 72 cycles later.
